gups_mem_slave: RTL and testbench

//  Synthesizable memory responder on the downstream side of the gups engine.

---
 rtl/gups_mem_slave_pkg.sv | 22 ++
 rtl/gups_mem_slave_ram.sv | 48 ++++
 rtl/gups_mem_slave.sv | 128 ++++++++++++
 tb/tb_gups_mem_slave.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gups_mem_slave_pkg.sv
// Shared definitions for the gups memory responder and the engine side:
// default geometry, FSM encoding and request-protocol constants.
package gups_mem_slave_pkg;
    localparam int DEF_ADDR_W = 13;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_RD_LAT = 2;
    localparam int DEF_WR_LAT = 5;
    localparam int REQ_ADDR_W = 64;

    localparam logic REQ_WR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_TURN = 2'd2
    } state_t;

    // True when any address bit above the implemented array depth is set.
    function automatic logic out_of_range(input logic [REQ_ADDR_W-1:0] a, input int aw);
        return (a >> aw) != '0;
    endfunction
endpackage

// File: rtl/gups_mem_slave_ram.sv
// Single-port DATA_W x 2**ADDR_W word array with synchronous read.
// The transaction port has priority; the backdoor preload uses the port otherwise.
module gups_mem_slave_ram #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              txn_en,
    input  logic              txn_we,
    input  logic [ADDR_W-1:0] txn_addr,
    input  logic [DATA_W-1:0] txn_wdata,
    input  logic              init_en,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_data,
    output logic [DATA_W-1:0] q
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        en = 1'b0;
        we = 1'b0;
        a  = init_addr;
        d  = init_data;
        if (txn_en) begin
            en = 1'b1;
            we = txn_we;
            a  = txn_addr;
            d  = txn_wdata;
        end else if (init_en) begin
            en = 1'b1;
            we = 1'b1;
        end
    end

    // NOTE: the array and its read register carry no reset; RAM macros cannot be reset
    // and the top masks q with its own reset-cleared flag.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[a] <= d;
            else    q      <= mem[a];
        end
    end
endmodule

// File: rtl/gups_mem_slave.sv
// Memory responder for the gups engine: single-outstanding req/wr/rdy protocol with fixed
// read/write latency, transaction counters and a sticky out-of-range flag.
module gups_mem_slave
    import gups_mem_slave_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = DEF_RD_LAT,
    parameter int WR_LAT = DEF_WR_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  wr,
    input  logic [REQ_ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rdy,
    input  logic                  init_en,
    input  logic [ADDR_W-1:0]     init_addr,
    input  logic [DATA_W-1:0]     init_data,
    output logic [31:0]           rd_cnt,
    output logic [31:0]           wr_cnt,
    output logic                  err
);
    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int LAT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    state_t            state;
    logic [LAT_W-1:0]  lat_cnt;
    logic              wr_q;
    logic              oor_q;
    logic              rdata_zero;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] ram_q;

    logic              accept;
    logic              req_oor;
    logic              fire;
    logic              done_wr;
    logic              done_oor;
    logic              in_rdy;
    logic              txn_rd;
    logic              txn_wr;
    logic [LAT_W-1:0]  lat_load;
    logic [ADDR_W-1:0] done_addr;

    // fire marks the edge that opens the rdy cycle; reads are issued on that edge so the
    // RAM output lands together with rdy, while writes commit on the edge closing it.
    always_comb begin
        accept    = (state == ST_IDLE) && req;
        req_oor   = out_of_range(addr, ADDR_W);
        lat_load  = (wr == REQ_WR) ? LAT_W'(WR_LAT - 1) : LAT_W'(RD_LAT - 1);
        fire      = (accept && (lat_load == '0)) ||
                    ((state == ST_BUSY) && (lat_cnt == LAT_W'(1)));
        done_wr   = accept ? wr      : wr_q;
        done_oor  = accept ? req_oor : oor_q;
        done_addr = accept ? addr[ADDR_W-1:0] : addr_q;
        in_rdy    = (state == ST_BUSY) && (lat_cnt == '0);
        txn_rd    = fire && !done_wr && !done_oor;
        txn_wr    = in_rdy && wr_q && !oor_q;
    end

    gups_mem_slave_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk       (clk),
        .txn_en    (txn_rd | txn_wr),
        .txn_we    (txn_wr),
        .txn_addr  (done_addr),
        .txn_wdata (wdata_q),
        .init_en   (init_en && (state == ST_IDLE) && !req),
        .init_addr (init_addr),
        .init_data (init_data),
        .q         (ram_q)
    );

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            lat_cnt    <= '0;
            wr_q       <= 1'b0;
            oor_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdy        <= 1'b0;
            rdata_zero <= 1'b1;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            err        <= 1'b0;
        end else begin
            rdy <= fire;
            if (fire) begin
                if (done_wr) begin
                    wr_cnt <= wr_cnt + 32'd1;
                end else begin
                    rd_cnt     <= rd_cnt + 32'd1;
                    rdata_zero <= done_oor;
                end
                if (done_oor) err <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (req) begin
                        wr_q    <= wr;
                        oor_q   <= req_oor;
                        addr_q  <= addr[ADDR_W-1:0];
                        wdata_q <= wdata;
                        lat_cnt <= lat_load;
                        state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (lat_cnt == '0) state   <= ST_TURN;
                    else               lat_cnt <= lat_cnt - LAT_W'(1);
                end
                ST_TURN: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rdata = rdata_zero ? '0 : ram_q;
endmodule

// File: tb/tb_gups_mem_slave.sv
// Bench for gups_mem_slave: directed protocol scenarios plus randomized traffic, all
// compared each cycle against a transaction-level model of the responder.
module tb_gups_mem_slave;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 64;
    localparam int RD_LAT = 2;
    localparam int WR_LAT = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req = 1'b0;
    logic              wr = 1'b0;
    logic [63:0]       addr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic [DATA_W-1:0] rdata;
    logic              rdy;
    logic              init_en = 1'b0;
    logic [ADDR_W-1:0] init_addr = '0;
    logic [DATA_W-1:0] init_data = '0;
    logic [31:0]       rd_cnt;
    logic [31:0]       wr_cnt;
    logic              err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gups_mem_slave #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT),
        .WR_LAT (WR_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .wr        (wr),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .rdy       (rdy),
        .init_en   (init_en),
        .init_addr (init_addr),
        .init_data (init_data),
        .rd_cnt    (rd_cnt),
        .wr_cnt    (wr_cnt),
        .err       (err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one request at a time, completion LAT cycles after accept,
    // responder free again LAT+2 cycles after accept. Stimulus only touches words 0..31.
    longint      cyc = 0;
    longint      m_done = 0;
    longint      m_free = 0;
    logic        m_pend = 1'b0;
    logic        m_wr_q = 1'b0;
    logic        m_oor = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [63:0] m_wdata = '0;
    logic        m_rdy = 1'b0;
    logic [31:0] m_rd = '0;
    logic [31:0] m_wr = '0;
    logic        m_err = 1'b0;
    logic [63:0] m_rdata = '0;
    logic [63:0] mem_m [32];

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_pend = 1'b0; m_rdy = 1'b0; m_rd = '0; m_wr = '0;
                m_err = 1'b0; m_rdata = '0; m_free = 0;
            end else begin
                longint ended;
                cyc++;
                ended = cyc - 1;
                if (m_pend && ended == m_done) begin
                    if (m_wr_q && !m_oor) mem_m[m_addr] = m_wdata;
                    m_pend = 1'b0;
                end
                if (ended >= m_free) begin
                    if (req) begin
                        m_wr_q  = wr;
                        m_oor   = (addr >= 64'h2000);
                        m_addr  = addr[4:0];
                        m_wdata = wdata;
                        m_done  = ended + (wr ? WR_LAT : RD_LAT);
                        m_free  = m_done + 2;
                        m_pend  = 1'b1;
                    end else if (init_en) begin
                        mem_m[init_addr[4:0]] = init_data;
                    end
                end
                m_rdy = m_pend && (cyc == m_done);
                if (m_rdy) begin
                    if (m_wr_q) m_wr = m_wr + 32'd1;
                    else begin
                        m_rd    = m_rd + 32'd1;
                        m_rdata = m_oor ? 64'd0 : mem_m[m_addr];
                    end
                    if (m_oor) m_err = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rdy", 64'(rdy), 64'(m_rdy));
                check("rdata", rdata, m_rdata);
                check("rd_cnt", 64'(rd_cnt), 64'(m_rd));
                check("wr_cnt", 64'(wr_cnt), 64'(m_wr));
                check("err", 64'(err), 64'(m_err));
            end
        end
    end

    // Drives one request from an idle cycle, returns the cycles to rdy and the data seen then.
    task automatic txn(input logic w, input logic [63:0] a, input logic [63:0] d,
                       output int lat, output logic [63:0] rd_val);
        logic seen = 1'b0;
        req = 1'b1; wr = w; addr = a; wdata = d;
        lat = 0; rd_val = '0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(negedge clk);
            if (rdy) begin
                seen = 1'b1; lat = n; rd_val = rdata;
            end
        end
        req = 1'b0;
        check("txn_done", 64'(seen), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic preload(input int a, input logic [63:0] d);
        init_en = 1'b1; init_addr = ADDR_W'(a); init_data = d;
        @(negedge clk);
        init_en = 1'b0;
    endtask

    task automatic rand_fields();
        wr    = 1'($urandom_range(1));
        wdata = {$urandom, $urandom};
        if ($urandom_range(7) == 0)
            addr = ((64'($urandom_range(1000)) + 64'd1) << 13) | 64'($urandom_range(31));
        else
            addr = 64'($urandom_range(31));
    endtask

    initial begin
        int          lat;
        logic [63:0] v;
        logic [31:0] base;
        int          pulses;
        int          first;
        int          last;
        int          bad_gap;
        int          rdy_seen;

        repeat (3) @(negedge clk);
        check("rst_rdy", 64'(rdy), 64'd0);
        check("rst_rdata", rdata, 64'd0);
        check("rst_rd_cnt", 64'(rd_cnt), 64'd0);
        check("rst_wr_cnt", 64'(wr_cnt), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 32; i++) preload(i, {$urandom, $urandom});

        // Backdoor then read.
        preload(5, 64'h10);
        txn(1'b0, 64'd5, 64'd0, lat, v);
        check("t1_lat", 64'(lat), 64'd2);
        check("t1_rdata", v, 64'h10);
        check("t1_rd_cnt", 64'(rd_cnt), 64'd1);

        // Write then read back.
        txn(1'b1, 64'd5, 64'h11, lat, v);
        check("t2_wr_lat", 64'(lat), 64'd5);
        txn(1'b0, 64'd5, 64'd0, lat, v);
        check("t2_rdata", v, 64'h11);
        check("t2_wr_cnt", 64'(wr_cnt), 64'd1);
        check("t2_rd_cnt", 64'(rd_cnt), 64'd2);

        // Held request: one service per RD_LAT+2 cycles, never twice.
        base = rd_cnt; pulses = 0; first = 0; last = 0; bad_gap = 0;
        req = 1'b1; wr = 1'b0; addr = 64'd7;
        for (int n = 1; n <= 200 && pulses < 20; n++) begin
            @(negedge clk);
            if (rdy) begin
                pulses++;
                if (pulses == 1) first = n;
                else if (n - last != 4) bad_gap++;
                last = n;
            end
        end
        req = 1'b0;
        repeat (6) @(negedge clk);
        check("t3_pulses", 64'(pulses), 64'd20);
        check("t3_first", 64'(first), 64'd2);
        check("t3_gaps", 64'(bad_gap), 64'd0);
        check("t3_rd_cnt", 64'(rd_cnt - base), 64'd20);

        // Out-of-range read and write.
        preload(0, 64'h5A5A);
        txn(1'b0, 64'h2000, 64'd0, lat, v);
        check("t4_lat", 64'(lat), 64'd2);
        check("t4_rdata", v, 64'd0);
        check("t4_err", 64'(err), 64'd1);
        txn(1'b1, 64'h2000, 64'hFF, lat, v);
        txn(1'b0, 64'd0, 64'd0, lat, v);
        check("t4_addr0", v, 64'h5A5A);
        check("t4_err_sticky", 64'(err), 64'd1);

        // Reset in the middle of a write.
        preload(9, 64'h99);
        rdy_seen = 0;
        req = 1'b1; wr = 1'b1; addr = 64'd9; wdata = 64'hAA;
        @(negedge clk);
        rdy_seen += int'(rdy);
        @(negedge clk);
        rst = 1'b0; req = 1'b0; wr = 1'b0;
        repeat (2) begin
            @(negedge clk);
            rdy_seen += int'(rdy);
        end
        check("t5_rd_cnt", 64'(rd_cnt), 64'd0);
        check("t5_wr_cnt", 64'(wr_cnt), 64'd0);
        check("t5_err", 64'(err), 64'd0);
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            rdy_seen += int'(rdy);
        end
        check("t5_no_rdy", 64'(rdy_seen), 64'd0);
        txn(1'b0, 64'd9, 64'd0, lat, v);
        check("t5_addr9", v, 64'h99);
        check("t5_rd_cnt_after", 64'(rd_cnt), 64'd1);

        // Backdoor pulse while busy is dropped.
        preload(12, 64'h1212);
        preload(13, 64'h1313);
        req = 1'b1; wr = 1'b0; addr = 64'd12;
        @(negedge clk);
        init_en = 1'b1; init_addr = 13'd13; init_data = 64'hDEAD;
        @(negedge clk);
        init_en = 1'b0;
        check("t6_rdy", 64'(rdy), 64'd1);
        check("t6_rdata", rdata, 64'h1212);
        req = 1'b0;
        repeat (2) @(negedge clk);
        txn(1'b0, 64'd13, 64'd0, lat, v);
        check("t6_addr13", v, 64'h1313);

        // Randomized traffic: held requests, mid-busy field changes, backdoor noise, resets.
        for (int c = 0; c < 4000; c++) begin
            rst = 1'b1;
            if (req && rdy) begin
                if ($urandom_range(3) != 0) req = 1'b0;
                else rand_fields();
            end else if (!req) begin
                if ($urandom_range(1) == 0) begin
                    req = 1'b1;
                    rand_fields();
                end
            end else if ($urandom_range(5) == 0) begin
                rand_fields();
            end
            init_en   = ($urandom_range(5) == 0);
            init_addr = ADDR_W'($urandom_range(31));
            init_data = {$urandom, $urandom};
            if ($urandom_range(799) == 0) begin
                rst = 1'b0;
                req = 1'b0;
            end
            @(negedge clk);
        end
        rst = 1'b1; req = 1'b0; init_en = 1'b0;
        repeat (8) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
